// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming Sobel edge-detection stage.
package sobel_pkg;

  localparam int unsigned COORD_WIDTH = 11;
  localparam int unsigned SUM_WIDTH   = 15;
  localparam logic [11:0] MAG_MAX     = 12'd4095;

  typedef logic [11:0]                 pixel_t;
  typedef logic signed [SUM_WIDTH-1:0] sum_t;

  typedef enum logic {
    MODE_GX = 1'b0,
    MODE_GY = 1'b1
  } sobel_mode_e;

  // a + 2b + c for one kernel column/row; 4 * 4095 fits without overflow
  function automatic sum_t tap_sum(pixel_t a, pixel_t b, pixel_t c);
    return sum_t'({3'b000, a}) + sum_t'({2'b00, b, 1'b0}) + sum_t'({3'b000, c});
  endfunction

endpackage

// File: rtl/sobel_filter_line_buffer.sv
// Single-port line RAM with asynchronous read-before-write; one image row deep.
module line_buffer #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = $clog2(IMG_WIDTH)
) (
  input  logic                  iCLK,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];

  // Read returns the old word in the same cycle the new one is written
  assign rdata = mem[addr];

  always_ff @(posedge iCLK) begin
    if (wren) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel gradient (|Gx| or |Gy|), 2-cycle latency, no stall.
// Optional binarisation enabled by defining SOBEL_THRESH_EN.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int unsigned           IMG_WIDTH  = 640,
  parameter int unsigned           DATA_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] THRESH     = 12'd1024
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [DATA_WIDTH-1:0] iDATA,
  input  logic [10:0]           iX_Cont,
  input  logic [10:0]           iY_Cont,
  input  logic                  iDVAL,
  input  logic                  iMODE,
  output logic [DATA_WIDTH-1:0] oDATA,
  output logic [10:0]           oX_Cont,
  output logic [10:0]           oY_Cont,
  output logic                  oDVAL
);

  localparam int unsigned ADDR_WIDTH = $clog2(IMG_WIDTH);
  localparam logic [COORD_WIDTH-1:0] X_LIMIT = COORD_WIDTH'(IMG_WIDTH);
  localparam sum_t SUM_MAG_MAX = sum_t'({3'b000, MAG_MAX});

  logic   accept;
  logic   frame_start;
  logic   [ADDR_WIDTH-1:0] lb_addr;
  pixel_t lb0_rdata;
  pixel_t lb1_rdata;

  assign accept      = iDVAL && (iX_Cont < X_LIMIT);
  assign frame_start = accept && (iX_Cont == '0) && (iY_Cont == '0);
  assign lb_addr     = iX_Cont[ADDR_WIDTH-1:0];

  line_buffer #(
    .IMG_WIDTH (IMG_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_lb0 (
    .iCLK (iCLK),
    .wren (accept),
    .addr (lb_addr),
    .wdata(iDATA),
    .rdata(lb0_rdata)
  );

  line_buffer #(
    .IMG_WIDTH (IMG_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_lb1 (
    .iCLK (iCLK),
    .wren (accept),
    .addr (lb_addr),
    .wdata(lb0_rdata),
    .rdata(lb1_rdata)
  );

  // Window indexed [row][col]; row 0 is the oldest line, col 0 the leftmost
  pixel_t      win [3][3];
  sobel_mode_e mode_q;
  logic        synced_q;
  logic        v1_q, zero1_q;
  logic [10:0] x1_q, y1_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
      mode_q   <= MODE_GX;
      synced_q <= 1'b0;
      v1_q     <= 1'b0;
      zero1_q  <= 1'b0;
      x1_q     <= '0;
      y1_q     <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1_rdata;
        win[1][2] <= lb0_rdata;
        win[2][2] <= iDATA;
        x1_q      <= iX_Cont - 11'd1;
        y1_q      <= iY_Cont - 11'd1;
        // Border windows span a line wrap or missing rows; unsynced ones see stale RAM
        zero1_q   <= (iX_Cont < 11'd2) || (iY_Cont < 11'd2) || !(synced_q || frame_start);
      end
      if (frame_start) begin
        mode_q   <= sobel_mode_e'(iMODE);
        synced_q <= 1'b1;
      end
    end
  end

  sum_t gx, gy;

  assign gx = tap_sum(win[0][2], win[1][2], win[2][2]) - tap_sum(win[0][0], win[1][0], win[2][0]);
  assign gy = tap_sum(win[2][0], win[2][1], win[2][2]) - tap_sum(win[0][0], win[0][1], win[0][2]);

  sum_t        g_q;
  logic        v2_q, zero2_q;
  logic [10:0] x2_q, y2_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      g_q     <= '0;
      v2_q    <= 1'b0;
      zero2_q <= 1'b0;
      x2_q    <= '0;
      y2_q    <= '0;
    end else begin
      g_q     <= (mode_q == MODE_GY) ? gy : gx;
      v2_q    <= v1_q;
      zero2_q <= zero1_q;
      x2_q    <= x1_q;
      y2_q    <= y1_q;
    end
  end

  sum_t   g_abs;
  pixel_t mag;
  pixel_t result;

  assign g_abs = g_q[SUM_WIDTH-1] ? -g_q : g_q;
  assign mag   = (g_abs > SUM_MAG_MAX) ? MAG_MAX : g_abs[11:0];

`ifdef SOBEL_THRESH_EN
  assign result = (mag >= THRESH) ? MAG_MAX : '0;
`else
  assign result = mag;
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDATA   <= '0;
      oX_Cont <= '0;
      oY_Cont <= '0;
      oDVAL   <= 1'b0;
    end else begin
      oDATA   <= zero2_q ? '0 : result;
      oX_Cont <= x2_q;
      oY_Cont <= y2_q;
      oDVAL   <= v2_q;
    end
  end

endmodule

// File: doc/sobel_filter.md
# sobel_filter

Streaming 3x3 Sobel edge-detection stage that sits directly downstream of the greyscale converter in the camera capture pipeline. It consumes one 12-bit grey pixel per valid cycle with its X/Y coordinates, and keeps the two previous image rows in internal line buffers. It emits the absolute horizontal or vertical gradient magnitude for the window centre, tagged with the centre's coordinates, for the display/SDRAM write path.

## Interface
Parameters:
- IMG_WIDTH, 640: grey pixels per line; line-buffer depth.
- DATA_WIDTH, 12: pixel width.
- THRESH, 12'd1024: binarization threshold; used only with SOBEL_THRESH_EN.

Ports:
- iCLK  in  1  pixel clock; single clock domain.
- iRST  in  1  reset; asynchronous, active-high.
- iDATA  in  DATA_WIDTH  grey pixel from greyscale stage.
- iX_Cont  in  11  pixel column.
- iY_Cont  in  11  pixel row.
- iDVAL  in  1  iDATA/iX_Cont/iY_Cont valid this cycle.
- iMODE  in  1  0 = Gx (vertical edges), 1 = Gy (horizontal edges).
- oDATA  out  DATA_WIDTH  gradient magnitude.
- oX_Cont  out  11  column of window centre.
- oY_Cont  out  11  row of window centre.
- oDVAL  out  1  output valid.

## Operation
- Pixel accepted when iDVAL=1 and iX_Cont < IMG_WIDTH. If iX_Cont >= IMG_WIDTH, the pixel is dropped: no buffer write, no shift, no output.
- Line buffers are addressed by iX_Cont and use read-before-write. On accept, LB0[x] returns row y-1 and LB1[x] returns row y-2. Then iDATA is written to LB0[x] and the old LB0[x] to LB1[x].
- Window: 3x3 register array. On accept, columns shift left, and the new right column is {LB1 out, LB0 out, iDATA}.
- Frame start is an accepted pixel with iX_Cont=0 and iY_Cont=0. iMODE is latched at frame start and held for the whole frame; iMODE changes mid-frame are ignored.
- Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20), where pRC is window row R (0 = oldest) and column C (0 = leftmost).
- Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02).
- Sums are signed 15-bit, with range ±16380 and no overflow. Output is |G| saturated to 4095.
- Output coordinates: for an input at (x,y), oX_Cont = x−1 and oY_Cont = y−1.
- Border: oDATA is forced to 0 (oDVAL still 1) when x<2 or y<2, because the window then spans a line wrap or missing rows.
- Reset mid-frame: after iRST deasserts, oDATA is forced to 0 (oDVAL still follows input) until the first frame start is seen. This hides stale line-buffer contents.

## Timing
- Reset values: oDATA=0, oX_Cont=0, oY_Cont=0, oDVAL=0; window registers 0; latched mode 0; "synced" flag 0. Line-buffer RAM contents are not reset.
- Pipeline is free-running with a valid tag and does not stall:
  - Edge N: window updated.
  - Edge N+1: partial sums registered.
  - Edge N+2: magnitude, coordinates and oDVAL registered.
- Fixed latency is 2 cycles from the iDVAL sampling edge to oDVAL high. This holds for any gap pattern in iDVAL.
- Back-to-back iDVAL gives back-to-back oDVAL. An idle input cycle gives oDVAL=0 two cycles later.
- oDVAL is a one-cycle pulse per accepted pixel. There is no backpressure; the consumer must accept every pulse.
- When a frame start and a reset release coincide, reset wins; the next frame start is used.

## Configuration
- SOBEL_THRESH_EN defined: oDATA = 4095 if the saturated |G| >= THRESH, else 0. The border and unsynced zeroing rules still apply. The compare adds no pipeline stage.
- Not defined: oDATA is the saturated magnitude, and THRESH is unused.

## Structure
- Package sobel_pkg holds:
  - COORD_WIDTH=11 and SUM_WIDTH=15.
  - MAG_MAX=4095.
  - Typedef pixel_t (logic [11:0]).
  - Typedef sum_t (logic signed [14:0]).
  - Enum sobel_mode_e {MODE_GX, MODE_GY}.
- Sub-module line_buffer: single-port read-before-write RAM, depth IMG_WIDTH and width DATA_WIDTH, with ports iCLK, wren, addr, wdata, rdata. Two instances.
- Top level contains the window, frame-start/mode latch, sync flag, sum stage and magnitude stage.

## Test plan
- Flat field: 640x480 frame, all pixels 2048, mode Gx. Every oDVAL has oDATA=0; 307200 pulses in total.
- Vertical step: columns <320 = 0, >=320 = 1000, mode Gx. Centres x=319 and x=320 (y>=1) give 4000; all other centres give 0. The same image in mode Gy gives 0 everywhere.
- Saturation and sign:
  - Step 0 to 4095 gives 4095, not 16380.
  - Falling step 1000 to 0 gives 4000 (absolute value).
  - Check that oX_Cont/oY_Cont equal input minus 1, 2 cycles later.
- Gapped input and border: insert random iDVAL gaps and one pixel with iX_Cont=700. Latency stays 2, the x=700 pixel produces no output, and rows 0-1 and columns 0-1 output 0.
- Reset and mode:
  - Pulse iRST at row 200, then resume input at row 201. Output is 0 until the next (0,0), then correct.
  - Toggle iMODE at row 100. It takes effect only from the next frame.
- With SOBEL_THRESH_EN and THRESH=1024: the vertical-step image outputs 4095 at x=319 and x=320 and 0 elsewhere; a step of 200 (G=800) outputs 0 everywhere.
